// File: rtl/nonce_search_ctrl_pkg.sv
// Shared types and defaults for the nonce search sequencer.
// State encoding is 3 bits wide; widths default to the 96/32/24 datapath.
package nonce_search_ctrl_pkg;

    localparam int DATA_W_DEF  = 96;
    localparam int NONCE_W_DEF = 32;
    localparam int HASH_W_DEF  = 24;
    localparam int TGT_W       = 8;
    localparam int RETRY_W     = 8;
    localparam int WDOG_W      = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT    = 3'd2,
        S_CHECK   = 3'd3,
        S_FOUND   = 3'd4,
        S_EXHAUST = 3'd5
    } state_e;

endpackage

// File: rtl/hash_watchdog.sv
// Wait-cycle counter for one hash launch.
// Counts while enabled, stops at TIMEOUT and flags expiry.
module hash_watchdog
    import nonce_search_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [WDOG_W-1:0] cnt_q;
    logic [WDOG_W-1:0] cnt_d;

    assign expired = (cnt_q == WDOG_W'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nonce_search_ctrl.sv
// Mining sequencer: walks the nonce range, one hash launch per nonce,
// and reports the first nonce whose hash beats the latched target.
module nonce_search_ctrl
    import nonce_search_ctrl_pkg::*;
#(
    parameter int                 DATA_W     = DATA_W_DEF,
    parameter int                 NONCE_W    = NONCE_W_DEF,
    parameter int                 HASH_W     = HASH_W_DEF,
    parameter logic [NONCE_W-1:0] NONCE_INIT = '0,
    parameter logic [NONCE_W-1:0] NONCE_MAX  = '1,
    parameter int                 TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DATA_W-1:0]         data_in,
    input  logic [TGT_W-1:0]          target,
    output logic                      hash_start,
    output logic [DATA_W+NONCE_W-1:0] hash_block,
    input  logic                      hash_done,
    input  logic [HASH_W-1:0]         hash_out,
    output logic                      busy,
    output logic                      finished,
    output logic [NONCE_W-1:0]        nonce_out,
    output logic                      exhausted,
    output logic [RETRY_W-1:0]        retries
);

    state_e state_q, state_d;

    logic [DATA_W-1:0]  data_q, data_d;
    logic [TGT_W-1:0]   target_q, target_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [HASH_W-1:0]  hash_q, hash_d;
    logic [NONCE_W-1:0] nonce_out_q, nonce_out_d;
    logic               finished_q, finished_d;
    logic               exhausted_q, exhausted_d;
    logic [RETRY_W-1:0] retries_q, retries_d;

    logic idle_like;
    logic wdog_clr;
    logic wdog_en;
    logic wdog_exp;
    logic pass;
    logic last;
    logic unused_hash_lo;

    hash_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (wdog_clr),
        .en      (wdog_en),
        .expired (wdog_exp)
    );

    assign idle_like = (state_q == S_IDLE) || (state_q == S_FOUND) ||
                       (state_q == S_EXHAUST);
    assign wdog_clr  = (state_q == S_LAUNCH);
    assign wdog_en   = (state_q == S_WAIT) && !hash_done;

    // Both upper hash bytes must be strictly below the target.
    assign pass = (hash_q[HASH_W-1 -: 8] < target_q) &&
                  (hash_q[HASH_W-9 -: 8] < target_q);
    assign last = (nonce_q == NONCE_MAX);

    assign unused_hash_lo = ^hash_q[HASH_W-17:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_FOUND, S_EXHAUST: begin
                if (start) state_d = S_LAUNCH;
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (hash_done)     state_d = S_CHECK;
                else if (wdog_exp) state_d = S_LAUNCH;
            end
            S_CHECK: begin
                if (pass)      state_d = S_FOUND;
                else if (last) state_d = S_EXHAUST;
                else           state_d = S_LAUNCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hash_start = (state_q == S_LAUNCH);
        busy       = (state_q == S_LAUNCH) || (state_q == S_WAIT) ||
                     (state_q == S_CHECK);
    end

    always_comb begin
        data_d      = data_q;
        target_d    = target_q;
        nonce_d     = nonce_q;
        hash_d      = hash_q;
        nonce_out_d = nonce_out_q;
        finished_d  = finished_q;
        exhausted_d = exhausted_q;
        retries_d   = retries_q;
        if (idle_like && start) begin
            data_d      = data_in;
            target_d    = target;
            nonce_d     = NONCE_INIT;
            finished_d  = 1'b0;
            exhausted_d = 1'b0;
            retries_d   = '0;
        end
        if (state_q == S_WAIT) begin
            if (hash_done) begin
                hash_d = hash_out;
            end else if (wdog_exp && (retries_q != '1)) begin
                retries_d = retries_q + 1'b1;
            end
        end
        if (state_q == S_CHECK) begin
            if (pass) begin
                nonce_out_d = nonce_q;
                finished_d  = 1'b1;
            end else if (last) begin
                exhausted_d = 1'b1;
            end else begin
                nonce_d = nonce_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q      <= '0;
            target_q    <= '0;
            nonce_q     <= '0;
            hash_q      <= '0;
            nonce_out_q <= '0;
            finished_q  <= 1'b0;
            exhausted_q <= 1'b0;
            retries_q   <= '0;
        end else begin
            data_q      <= data_d;
            target_q    <= target_d;
            nonce_q     <= nonce_d;
            hash_q      <= hash_d;
            nonce_out_q <= nonce_out_d;
            finished_q  <= finished_d;
            exhausted_q <= exhausted_d;
            retries_q   <= retries_d;
        end
    end

    assign hash_block = {data_q, nonce_q};
    assign finished   = finished_q;
    assign nonce_out  = nonce_out_q;
    assign exhausted  = exhausted_q;
    assign retries    = retries_q;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Bench for nonce_search_ctrl: table-driven hash core (L=3) plus
// a reference that predicts launch order, spacing and search outcome.
module tb_nonce_search_ctrl;

    localparam int L   = 3;
    localparam int TMO = 10;
    localparam int NMAX = 7;

    logic         clk;
    logic         reset;
    logic         start;
    logic [95:0]  data_in;
    logic [7:0]   target;
    logic         hash_start;
    logic [127:0] hash_block;
    logic         hash_done;
    logic [23:0]  hash_out;
    logic         busy;
    logic         finished;
    logic [31:0]  nonce_out;
    logic         exhausted;
    logic [7:0]   retries;

    nonce_search_ctrl #(
        .NONCE_INIT (32'd0),
        .NONCE_MAX  (32'd7),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .data_in    (data_in),
        .target     (target),
        .hash_start (hash_start),
        .hash_block (hash_block),
        .hash_done  (hash_done),
        .hash_out   (hash_out),
        .busy       (busy),
        .finished   (finished),
        .nonce_out  (nonce_out),
        .exhausted  (exhausted),
        .retries    (retries)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Hash core model state
    logic [23:0] tbl [8];
    bit          drop [8];
    bit          dropped [8];
    bit          core_on;
    int          ncyc = 0;
    int          due_q [$];
    logic [31:0] dn_q [$];
    int          lt_q [$];
    logic [31:0] ln_q [$];
    logic [95:0] lh_q [$];
    logic [31:0] mn;

    always @(negedge clk) begin
        ncyc++;
        if (core_on) begin
            hash_done = 1'b0;
            hash_out  = 24'($urandom);
            if (due_q.size() != 0 && due_q[0] == ncyc) begin
                hash_done = 1'b1;
                hash_out  = tbl[dn_q[0][2:0]];
                void'(due_q.pop_front());
                void'(dn_q.pop_front());
            end
            if (hash_start) begin
                mn = hash_block[31:0];
                lt_q.push_back(ncyc);
                ln_q.push_back(mn);
                lh_q.push_back(hash_block[127:32]);
                if (drop[mn[2:0]] && !dropped[mn[2:0]]) begin
                    dropped[mn[2:0]] = 1'b1;
                end else begin
                    due_q.push_back(ncyc + L);
                    dn_q.push_back(mn);
                end
            end
        end
    end

    task automatic clear_model();
        due_q.delete();
        dn_q.delete();
        lt_q.delete();
        ln_q.delete();
        lh_q.delete();
        for (int i = 0; i < 8; i++) dropped[i] = 1'b0;
    endtask

    function automatic bit pass_ref(input logic [23:0] h, input logic [7:0] t);
        return (h[23:16] < t) && (h[15:8] < t);
    endfunction

    task automatic run_search(input logic [95:0] d, input logic [7:0] t,
                              input bit mid_start, input string name);
        int exp_ln [$];
        bit exp_found;
        int exp_n;
        int exp_retries;
        int n;
        int gap;
        exp_found   = 1'b0;
        exp_n       = 0;
        exp_retries = 0;
        for (int k = 0; k <= NMAX; k++) begin
            exp_ln.push_back(k);
            if (drop[k]) begin
                exp_ln.push_back(k);
                exp_retries++;
            end
            if (pass_ref(tbl[k], t)) begin
                exp_found = 1'b1;
                exp_n     = k;
                break;
            end
        end
        clear_model();
        @(negedge clk);
        start   = 1'b1;
        data_in = d;
        target  = t;
        @(negedge clk);
        start   = 1'b0;
        data_in = {$urandom, $urandom, $urandom};
        target  = 8'($urandom);
        if (mid_start) begin
            @(negedge clk);
            check({name, "_busy_mid"}, busy, 1'b1);
            start   = 1'b1;
            data_in = 96'h3c87edfd24331f6b6c9eca40;
            target  = 8'd255;
            @(negedge clk);
            start   = 1'b0;
        end
        n = 0;
        while (!(finished || exhausted) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check({name, "_timeout"}, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check({name, "_finished"}, finished, exp_found);
        check({name, "_exhausted"}, exhausted, !exp_found);
        check({name, "_both"}, finished && exhausted, 1'b0);
        if (exp_found) check({name, "_nonce_out"}, nonce_out, exp_n);
        check({name, "_retries"}, retries, exp_retries);
        check({name, "_busy_end"}, busy, 1'b0);
        check({name, "_nlaunch"}, ln_q.size(), exp_ln.size());
        for (int i = 0; i < exp_ln.size() && i < ln_q.size(); i++) begin
            check({name, "_lnonce"}, ln_q[i], exp_ln[i]);
            check({name, "_lhdr"}, lh_q[i], d);
            if (i > 0) begin
                gap = (exp_ln[i] == exp_ln[i-1]) ? TMO + 2 : L + 2;
                check({name, "_gap"}, lt_q[i] - lt_q[i-1], gap);
            end
        end
        check({name, "_blk_hdr"}, hash_block[127:32], d);
        check({name, "_blk_nonce"}, hash_block[31:0],
              exp_ln[exp_ln.size()-1]);
    endtask

    task automatic set_fail_table(input int pass_at);
        for (int i = 0; i < 8; i++) begin
            tbl[i]  = {8'hF0, 8'($urandom), 8'($urandom)};
            drop[i] = 1'b0;
        end
        if (pass_at >= 0) tbl[pass_at] = 24'h102030;
    endtask

    task automatic stray_done(input string name, input bit exp_ex);
        core_on = 1'b0;
        @(negedge clk);
        hash_done = 1'b1;
        hash_out  = 24'h000000;
        @(negedge clk);
        hash_done = 1'b0;
        repeat (3) @(negedge clk);
        check({name, "_finished"}, finished, 1'b0);
        check({name, "_exhausted"}, exhausted, exp_ex);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_lnch"}, hash_start, 1'b0);
        core_on = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        data_in   = '0;
        target    = '0;
        hash_done = 1'b0;
        hash_out  = '0;
        core_on   = 1'b1;
        set_fail_table(-1);
        repeat (3) @(negedge clk);
        check("rst_blk", hash_block, 128'h0);
        check("rst_outs", {hash_start, busy, finished, exhausted, retries,
                           nonce_out}, 44'h0);
        reset = 1'b1;

        set_fail_table(5);
        run_search(96'h397d9f2f40ca9e6c6b1f3324, 8'd150, 1'b0, "t1");

        for (int i = 0; i < 8; i++) tbl[i] = 24'h000000;
        run_search({$urandom, $urandom, $urandom}, 8'd0, 1'b0, "t2");
        stray_done("t6ex", 1'b1);

        set_fail_table(5);
        drop[2] = 1'b1;
        run_search(96'h397d9f2f40ca9e6c6b1f3324, 8'd150, 1'b0, "t3");

        set_fail_table(5);
        run_search(96'h397d9f2f40ca9e6c6b1f3324, 8'd150, 1'b1, "t4");

        // Asynchronous reset while waiting on the core
        set_fail_table(-1);
        clear_model();
        @(negedge clk);
        start   = 1'b1;
        data_in = 96'h0123456789abcdef01234567;
        target  = 8'd200;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("t5_busy", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("t5_blk", hash_block, 128'h0);
        check("t5_outs", {hash_start, busy, finished, exhausted, retries,
                          nonce_out}, 44'h0);
        @(negedge clk);
        reset = 1'b1;
        stray_done("t6idle", 1'b0);
        set_fail_table(3);
        run_search(96'h0123456789abcdef01234567, 8'd200, 1'b0, "t5r");

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) begin
                tbl[i]  = 24'($urandom);
                drop[i] = ($urandom_range(0, 5) == 0);
            end
            run_search({$urandom, $urandom, $urandom},
                       8'($urandom_range(0, 255)),
                       1'($urandom_range(0, 1)), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
